arb_stream_mux: RTL and testbench

- Downstream data-path stage for the TMR-voted round-robin arbiter. It drives the arbiter's request and acknowledge inputs and consumes its grant, grant_valid and grant_encoded outputs.
- It routes the granted AXI-Stream-style source to a single registered master port through a 2-entry skid buffer, holding the grant for a whole packet.
- It flags any inconsistency between the voted grant vectors (sticky error).
- The arbiter must be configured with ARB_BLOCK=1 and ARB_BLOCK_ACK=1.

---
 rtl/arb_stream_mux.sv | 131 +++++++++++++
 tb/tb_arb_stream_mux.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_stream_mux.sv
// arb_stream_mux: routes the arbiter-granted stream source to a single
// registered master port through a 2-entry skid buffer (output register plus
// one temp entry). The grant is held for a whole packet through the
// acknowledge path. Inconsistent grant vectors raise a sticky error.
module arb_stream_mux #(
    parameter int PORTS       = 4,
    parameter int DATA_WIDTH  = 32,
    parameter bit LAST_ENABLE = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [PORTS-1:0]            s_tvalid,
    input  logic [PORTS-1:0]            s_tlast,
    output logic [PORTS-1:0]            s_tready,
    output logic [PORTS-1:0]            arb_request,
    output logic [PORTS-1:0]            arb_acknowledge,
    input  logic [PORTS-1:0]            arb_grant,
    input  logic                        arb_grant_valid,
    input  logic [$clog2(PORTS)-1:0]    arb_grant_encoded,
    output logic [DATA_WIDTH-1:0]       m_tdata,
    output logic                        m_tvalid,
    output logic                        m_tlast,
    input  logic                        m_tready,
    output logic                        busy,
    output logic                        grant_error
);
    localparam int SEL_W = $clog2(PORTS);

    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [PORTS-1:0]      w_last_vec;
    logic [PORTS-1:0]      w_grant_onehot;
    logic                  w_accept;
    logic                  w_acc_last;
    logic                  w_ready_int_next;
    logic                  w_grant_bad;

    logic                  r_ready_int;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic [DATA_WIDTH-1:0] r_tmp_tdata;
    logic                  r_tmp_tvalid;
    logic                  r_tmp_tlast;
    logic                  r_grant_error;

    // Pick the source addressed by the encoded grant index.
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (arb_grant_encoded == SEL_W'(i)) begin
                w_sel_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_valid = s_tvalid[i];
                w_sel_last  = s_tlast[i];
            end
        end
    end

    // Without packet framing every beat closes its own "packet".
    assign w_last_vec      = LAST_ENABLE ? s_tlast : '1;
    assign w_acc_last      = LAST_ENABLE ? w_sel_last : 1'b1;

    assign arb_request     = s_tvalid;
    assign s_tready        = {PORTS{arb_grant_valid & r_ready_int}} & arb_grant;
    assign w_accept        = arb_grant_valid & w_sel_valid & r_ready_int;
    assign arb_acknowledge = arb_grant & s_tvalid & s_tready & w_last_vec;

    // ready_int is registered; the temp entry absorbs the one beat accepted
    // while the output is stalled and ready_int has not yet fallen.
    assign w_ready_int_next = m_tready | (~r_tmp_tvalid & (~r_m_tvalid | ~w_accept));

    // An out-of-range encoded index shifts to zero and is flagged as well.
    assign w_grant_onehot = PORTS'(1) << arb_grant_encoded;
    assign w_grant_bad    = arb_grant_valid ? (arb_grant != w_grant_onehot)
                                            : (arb_grant != '0);

    // Skid buffer: output register plus one temp entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready_int  <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_tmp_tdata  <= '0;
            r_tmp_tvalid <= 1'b0;
            r_tmp_tlast  <= 1'b0;
        end else begin
            r_ready_int <= w_ready_int_next;
            if (r_ready_int) begin
                if (m_tready || !r_m_tvalid) begin
                    r_m_tvalid <= w_accept;
                    if (w_accept) begin
                        r_m_tdata <= w_sel_data;
                        r_m_tlast <= w_acc_last;
                    end
                end else if (w_accept) begin
                    r_tmp_tvalid <= 1'b1;
                    r_tmp_tdata  <= w_sel_data;
                    r_tmp_tlast  <= w_acc_last;
                end
            end else if (m_tready) begin
                r_m_tvalid   <= r_tmp_tvalid;
                r_tmp_tvalid <= 1'b0;
                if (r_tmp_tvalid) begin
                    r_m_tdata <= r_tmp_tdata;
                    r_m_tlast <= r_tmp_tlast;
                end
            end
        end
    end

    // Sticky grant consistency flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_error <= 1'b0;
        end else if (w_grant_bad) begin
            r_grant_error <= 1'b1;
        end
    end

    assign m_tdata     = r_m_tdata;
    assign m_tvalid    = r_m_tvalid;
    assign m_tlast     = r_m_tlast;
    assign busy        = r_m_tvalid | r_tmp_tvalid | arb_grant_valid;
    assign grant_error = r_grant_error;

endmodule

// File: tb/tb_arb_stream_mux.sv
// Directed bench for arb_stream_mux with a blocking round-robin arbiter model
// (grant held until acknowledge, one idle grant cycle before re-arbitration).
module tb_arb_stream_mux;
    localparam int P  = 4;
    localparam int DW = 32;
    localparam int TR = 128;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [P*DW-1:0] s_tdata;
    logic [P-1:0]    s_tvalid, s_tlast, s_tready;
    logic [P-1:0]    arb_request, arb_acknowledge, arb_grant;
    logic            arb_grant_valid;
    logic [1:0]      arb_grant_encoded;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid, m_tlast, m_tready, busy, grant_error;

    int n_checks = 0;
    int n_fail   = 0;

    arb_stream_mux #(.PORTS(P), .DATA_WIDTH(DW), .LAST_ENABLE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .arb_request(arb_request), .arb_acknowledge(arb_acknowledge),
        .arb_grant(arb_grant), .arb_grant_valid(arb_grant_valid),
        .arb_grant_encoded(arb_grant_encoded),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .busy(busy), .grant_error(grant_error)
    );

    // Arbiter model plus an override used to inject bad grant vectors.
    logic [P-1:0] mdl_grant;
    logic         mdl_gv;
    logic [1:0]   mdl_enc;
    int           mdl_last;
    int           mdl_pick;
    logic         mdl_found;
    logic         ovr = 1'b0;
    logic [P-1:0] ovr_grant = '0;
    logic         ovr_gv = 1'b0;
    logic [1:0]   ovr_enc = '0;

    always_comb begin
        mdl_found = 1'b0;
        mdl_pick  = 0;
        for (int k = 1; k <= P; k++) begin
            if (!mdl_found && arb_request[(mdl_last + k) % P]) begin
                mdl_found = 1'b1;
                mdl_pick  = (mdl_last + k) % P;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_grant <= '0; mdl_gv <= 1'b0; mdl_enc <= '0; mdl_last <= P - 1;
        end else if (mdl_gv) begin
            if ((mdl_grant & arb_acknowledge) != '0) begin
                mdl_grant <= '0; mdl_gv <= 1'b0;
            end
        end else if (mdl_found) begin
            mdl_grant <= 4'(1) << mdl_pick;
            mdl_gv    <= 1'b1;
            mdl_enc   <= 2'(mdl_pick);
            mdl_last  <= mdl_pick;
        end
    end

    assign arb_grant         = ovr ? ovr_grant : mdl_grant;
    assign arb_grant_valid   = ovr ? ovr_gv    : mdl_gv;
    assign arb_grant_encoded = ovr ? ovr_enc   : mdl_enc;

    // Source beat tables.
    logic [DW-1:0] src_data [P][16];
    logic          src_last [P][16];
    int            src_gap  [P][16];
    int            src_len  [P];
    int            src_ptr  [P];
    int            src_wait [P];

    // Per-cycle trace and captured output beats.
    logic          tr_mtv [TR];
    logic          tr_mtr [TR];
    logic [DW-1:0] tr_data[TR];
    logic          tr_last[TR];
    logic [P-1:0]  tr_str [TR];
    logic [P-1:0]  tr_ack [TR];
    logic [P-1:0]  tr_fire[TR];
    logic [DW-1:0] out_d[$];
    logic          out_l[$];
    int            out_c[$];
    int            cyc;
    int            tready_mode;
    logic [3:0]    pat = 4'b1001;

    task automatic clear_src();
        for (int p = 0; p < P; p++) begin
            src_len[p] = 0; src_ptr[p] = 0; src_wait[p] = 0;
        end
    endtask

    task automatic add_beat(input int p, input logic [DW-1:0] d, input logic l, input int gap);
        src_data[p][src_len[p]] = d;
        src_last[p][src_len[p]] = l;
        src_gap[p][src_len[p]]  = gap;
        if (src_len[p] == 0) src_wait[p] = gap;
        src_len[p]++;
    endtask

    task automatic do_reset();
        rst = 1'b1; ovr = 1'b0; m_tready = 1'b1;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic begin_test();
        do_reset();
        clear_src();
        out_d.delete(); out_l.delete(); out_c.delete();
        cyc = 0; tready_mode = 0;
    endtask

    // One clock cycle: drive at negedge, sample, then advance sources.
    task automatic step();
        logic [P-1:0] fire;
        for (int p = 0; p < P; p++) begin
            if (src_ptr[p] < src_len[p] && src_wait[p] == 0) begin
                s_tvalid[p] = 1'b1;
                s_tdata[p*DW +: DW] = src_data[p][src_ptr[p]];
                s_tlast[p] = src_last[p][src_ptr[p]];
            end else begin
                s_tvalid[p] = 1'b0;
                s_tdata[p*DW +: DW] = '0;
                s_tlast[p] = 1'b0;
            end
        end
        m_tready = (tready_mode == 0) ? 1'b1 : pat[cyc % 4];
        #1;
        fire = s_tvalid & s_tready;
        if (cyc < TR) begin
            tr_mtv[cyc] = m_tvalid; tr_mtr[cyc] = m_tready; tr_data[cyc] = m_tdata;
            tr_last[cyc] = m_tlast; tr_str[cyc] = s_tready; tr_ack[cyc] = arb_acknowledge;
            tr_fire[cyc] = fire;
        end
        if (m_tvalid && m_tready) begin
            out_d.push_back(m_tdata); out_l.push_back(m_tlast); out_c.push_back(cyc);
        end
        @(posedge clk);
        for (int p = 0; p < P; p++) begin
            if (fire[p]) begin
                src_ptr[p]++;
                if (src_ptr[p] < src_len[p]) src_wait[p] = src_gap[p][src_ptr[p]];
            end else if (src_wait[p] > 0 && src_ptr[p] < src_len[p]) begin
                src_wait[p]--;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        ovr = 1'b0; m_tready = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0;
        #1;
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_mtvalid: got %b expected 0", m_tvalid); end
        n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_mtlast: got %b expected 0", m_tlast); end
        n_checks++; if (m_tdata !== '0) begin n_fail++; $display("FAIL reset_mtdata: got %h expected 0", m_tdata); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (grant_error !== 1'b0) begin n_fail++; $display("FAIL reset_gerr: got %b expected 0", grant_error); end
        ovr = 1'b1; ovr_grant = 4'b0100; ovr_gv = 1'b1; ovr_enc = 2'd2;
        s_tvalid = 4'b0100;
        #1;
        n_checks++; if (s_tready !== 4'b0000) begin n_fail++; $display("FAIL reset_stready: got %b expected 0000", s_tready); end
        @(posedge clk); #1;
        n_checks++; if (s_tready !== 4'b0000) begin n_fail++; $display("FAIL reset_stready_edge: got %b expected 0000", s_tready); end
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_mtvalid_edge: got %b expected 0", m_tvalid); end
        ovr = 1'b0; s_tvalid = '0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int f[$];
        int ack_n, ack_c;
        logic [P-1:0] ack_v;
        begin_test();
        for (int k = 0; k < 4; k++) add_beat(2, 32'h10 + k, k == 3, 0);
        while (out_d.size() < 4 && cyc < 40) step();
        for (int k = 0; k < 3; k++) step();
        n_checks++; if (out_d.size() !== 4) begin n_fail++; $display("FAIL single_count: got %0d expected 4", out_d.size()); end
        for (int k = 0; k < 4; k++) begin
            if (k < out_d.size()) begin
                n_checks++; if (out_d[k] !== 32'h10 + k) begin n_fail++; $display("FAIL single_data%0d: got %h expected %h", k, out_d[k], 32'h10 + k); end
                n_checks++; if (out_l[k] !== (k == 3)) begin n_fail++; $display("FAIL single_last%0d: got %b expected %b", k, out_l[k], k == 3); end
                n_checks++; if (out_c[k] !== out_c[0] + k) begin n_fail++; $display("FAIL single_cycle%0d: got %0d expected %0d", k, out_c[k], out_c[0] + k); end
            end
        end
        ack_n = 0; ack_c = -1; ack_v = '0;
        for (int c = 0; c < cyc && c < TR; c++) begin
            if (tr_fire[c][2]) f.push_back(c);
            if (tr_ack[c] != '0) begin ack_n++; ack_c = c; ack_v = tr_ack[c]; end
        end
        if (f.size() > 0 && out_d.size() > 0) begin
            n_checks++; if (out_c[0] !== f[0] + 1) begin n_fail++; $display("FAIL single_latency: got cycle %0d expected %0d", out_c[0], f[0] + 1); end
        end
        n_checks++; if (ack_n !== 1) begin n_fail++; $display("FAIL single_ack_count: got %0d expected 1", ack_n); end
        n_checks++; if (ack_v !== 4'b0100) begin n_fail++; $display("FAIL single_ack_value: got %b expected 0100", ack_v); end
        if (f.size() == 4) begin
            n_checks++; if (ack_c !== f[3]) begin n_fail++; $display("FAIL single_ack_cycle: got %0d expected %0d", ack_c, f[3]); end
        end
        n_checks++; if (grant_error !== 1'b0) begin n_fail++; $display("FAIL single_gerr: got %b expected 0", grant_error); end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] exp_d [8];
        exp_d = '{32'h20, 32'h21, 32'h30, 32'h31, 32'h22, 32'h23, 32'h32, 32'h33};
        begin_test();
        for (int k = 0; k < 4; k++) begin
            add_beat(0, 32'h20 + k, k[0], 0);
            add_beat(1, 32'h30 + k, k[0], 0);
        end
        while (out_d.size() < 8 && cyc < 60) step();
        for (int k = 0; k < 3; k++) step();
        n_checks++; if (out_d.size() !== 8) begin n_fail++; $display("FAIL rr_count: got %0d expected 8", out_d.size()); end
        for (int k = 0; k < 8; k++) begin
            if (k < out_d.size()) begin
                n_checks++; if (out_d[k] !== exp_d[k]) begin n_fail++; $display("FAIL rr_data%0d: got %h expected %h", k, out_d[k], exp_d[k]); end
                n_checks++; if (out_l[k] !== (k % 2 == 1)) begin n_fail++; $display("FAIL rr_last%0d: got %b expected %b", k, out_l[k], k % 2 == 1); end
            end
            if (k < 7 && k + 1 < out_d.size()) begin
                n_checks++; if (out_c[k+1] - out_c[k] !== ((k % 2 == 1) ? 2 : 1)) begin n_fail++; $display("FAIL rr_gap%0d: got %0d expected %0d", k, out_c[k+1] - out_c[k], (k % 2 == 1) ? 2 : 1); end
            end
        end
        n_checks++; if (grant_error !== 1'b0) begin n_fail++; $display("FAIL rr_gerr: got %b expected 0", grant_error); end
    endtask

    task automatic test_backpressure();
        int s;
        begin_test();
        tready_mode = 1;
        for (int k = 0; k < 8; k++) add_beat(3, 32'hA0 + k, k == 7, 0);
        while (out_d.size() < 8 && cyc < 80) step();
        for (int k = 0; k < 4; k++) step();
        n_checks++; if (out_d.size() !== 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", out_d.size()); end
        for (int k = 0; k < 8; k++) begin
            if (k < out_d.size()) begin
                n_checks++; if (out_d[k] !== 32'hA0 + k) begin n_fail++; $display("FAIL bp_data%0d: got %h expected %h", k, out_d[k], 32'hA0 + k); end
                n_checks++; if (out_l[k] !== (k == 7)) begin n_fail++; $display("FAIL bp_last%0d: got %b expected %b", k, out_l[k], k == 7); end
            end
        end
        s = -1;
        for (int c = 1; c < cyc && c < TR; c++) begin
            if (tr_mtv[c-1] && !tr_mtr[c-1]) begin
                n_checks++;
                if (tr_mtv[c] !== 1'b1 || tr_data[c] !== tr_data[c-1] || tr_last[c] !== tr_last[c-1]) begin
                    n_fail++; $display("FAIL bp_stable_c%0d: got v=%b d=%h expected v=1 d=%h", c, tr_mtv[c], tr_data[c], tr_data[c-1]);
                end
            end
        end
        for (int c = 0; c < cyc && c < TR; c++) if (s < 0 && tr_mtv[c] && !tr_mtr[c]) s = c;
        n_checks++; if (s < 0) begin n_fail++; $display("FAIL bp_no_stall: got none expected a stall cycle"); end
        if (s >= 0 && s + 1 < TR) begin
            n_checks++; if (tr_str[s][3] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_at_stall: got %b expected 1", tr_str[s][3]); end
            n_checks++; if (tr_str[s+1][3] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_after_stall: got %b expected 0", tr_str[s+1][3]); end
        end
    endtask

    task automatic test_bubble();
        logic [DW-1:0] exp_d [5];
        logic [P-1:0] acks[$];
        int p1_end, early;
        exp_d = '{32'h40, 32'h41, 32'h42, 32'h50, 32'h51};
        begin_test();
        add_beat(1, 32'h40, 1'b0, 0);
        add_beat(1, 32'h41, 1'b0, 3);
        add_beat(1, 32'h42, 1'b1, 0);
        add_beat(0, 32'h50, 1'b0, 1);
        add_beat(0, 32'h51, 1'b1, 0);
        while (out_d.size() < 5 && cyc < 60) step();
        for (int k = 0; k < 3; k++) step();
        n_checks++; if (out_d.size() !== 5) begin n_fail++; $display("FAIL bub_count: got %0d expected 5", out_d.size()); end
        for (int k = 0; k < 5; k++) begin
            if (k < out_d.size()) begin
                n_checks++; if (out_d[k] !== exp_d[k]) begin n_fail++; $display("FAIL bub_data%0d: got %h expected %h", k, out_d[k], exp_d[k]); end
            end
        end
        p1_end = TR;
        for (int c = 0; c < cyc && c < TR; c++) begin
            if (tr_ack[c] != '0) acks.push_back(tr_ack[c]);
            if (tr_ack[c][1] && p1_end == TR) p1_end = c;
        end
        n_checks++; if (acks.size() !== 2) begin n_fail++; $display("FAIL bub_ack_count: got %0d expected 2", acks.size()); end
        if (acks.size() == 2) begin
            n_checks++; if (acks[0] !== 4'b0010) begin n_fail++; $display("FAIL bub_ack0: got %b expected 0010", acks[0]); end
            n_checks++; if (acks[1] !== 4'b0001) begin n_fail++; $display("FAIL bub_ack1: got %b expected 0001", acks[1]); end
        end
        early = 0;
        for (int c = 0; c <= p1_end && c < cyc && c < TR; c++) if (tr_str[c][0]) early++;
        n_checks++; if (early !== 0) begin n_fail++; $display("FAIL bub_port0_stall: got %0d ready cycles expected 0", early); end
    endtask

    task automatic test_grant_error();
        begin_test();
        ovr = 1'b1; ovr_grant = 4'b0100; ovr_gv = 1'b1; ovr_enc = 2'd2;
        @(posedge clk); @(negedge clk);
        ovr = 1'b0; #1;
        n_checks++; if (grant_error !== 1'b0) begin n_fail++; $display("FAIL gerr_consistent: got %b expected 0", grant_error); end
        @(negedge clk);
        ovr = 1'b1; ovr_grant = 4'b0011; ovr_gv = 1'b1; ovr_enc = 2'd0;
        #1;
        n_checks++; if (grant_error !== 1'b0) begin n_fail++; $display("FAIL gerr_before_edge: got %b expected 0", grant_error); end
        @(posedge clk); @(negedge clk);
        ovr = 1'b0; #1;
        n_checks++; if (grant_error !== 1'b1) begin n_fail++; $display("FAIL gerr_set: got %b expected 1", grant_error); end
        @(negedge clk);
        for (int k = 0; k < 5; k++) step();
        n_checks++; if (grant_error !== 1'b1) begin n_fail++; $display("FAIL gerr_sticky: got %b expected 1", grant_error); end
        do_reset();
        n_checks++; if (grant_error !== 1'b0) begin n_fail++; $display("FAIL gerr_cleared: got %b expected 0", grant_error); end
        ovr = 1'b1; ovr_grant = 4'b0010; ovr_gv = 1'b0; ovr_enc = 2'd1;
        @(posedge clk); @(negedge clk);
        ovr = 1'b0; #1;
        n_checks++; if (grant_error !== 1'b1) begin n_fail++; $display("FAIL gerr_invalid_nonzero: got %b expected 1", grant_error); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        begin_test();
        for (int k = 0; k < 6; k++) add_beat(2, 32'h60 + k, k == 5, 0);
        while (out_d.size() < 2 && cyc < 20) step();
        n_checks++; if (m_tvalid !== 1'b1 || s_tready[2] !== 1'b1) begin n_fail++; $display("FAIL arst_midpacket: got v=%b r=%b expected v=1 r=1", m_tvalid, s_tready[2]); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL arst_mtvalid: got %b expected 0", m_tvalid); end
        n_checks++; if (s_tready !== 4'b0000) begin n_fail++; $display("FAIL arst_stready: got %b expected 0000", s_tready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0", busy); end
        @(posedge clk); @(negedge clk);
        clear_src();
        out_d.delete(); out_l.delete(); out_c.delete();
        cyc = 0;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) add_beat(1, 32'h70 + k, k == 2, 0);
        while (out_d.size() < 3 && cyc < 30) step();
        for (int k = 0; k < 3; k++) step();
        n_checks++; if (out_d.size() !== 3) begin n_fail++; $display("FAIL arst_after_count: got %0d expected 3", out_d.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < out_d.size()) begin
                n_checks++; if (out_d[k] !== 32'h70 + k || out_l[k] !== (k == 2)) begin n_fail++; $display("FAIL arst_after%0d: got %h/%b expected %h/%b", k, out_d[k], out_l[k], 32'h70 + k, k == 2); end
            end
        end
    endtask

    initial begin
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
        clear_src();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_bubble();
        test_grant_error();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
